// File: rtl/if_sa_cache.sv
// Instruction-fetch stage with an N-way set-associative, one-word-per-line cache.
// Refills go to mem_ctrl over req/done; define IF_PREFETCH_EN for next-line prefetch.
module if_sa_cache #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned IDX_W  = 7,
    parameter int unsigned WAYS   = 2,
    parameter int unsigned TAG_W  = ADDR_W - IDX_W - 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              flush_i,
    output logic [31:0]       inst_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic              if_stall,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [31:0]       mem_data_i,
    input  logic              mem_done_i
);

    localparam int unsigned SETS = 1 << IDX_W;
    localparam int unsigned VW   = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ
`ifdef IF_PREFETCH_EN
        , S_PF
`endif
    } state_t;

    logic              r_valid  [SETS][WAYS];
    logic [TAG_W-1:0]  r_tag    [SETS][WAYS];
    logic [31:0]       r_data   [SETS][WAYS];
    logic [VW-1:0]     r_victim [SETS];

    state_t            r_state;
    logic              r_mem_req;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_drop;

    logic [IDX_W-1:0]  w_idx;
    logic [TAG_W-1:0]  w_tag;
    logic              w_hit;
    logic [31:0]       w_hit_data;
    logic              w_fwd;
    logic              w_miss;
    logic              w_fill;
    logic [IDX_W-1:0]  w_fill_idx;
    logic [TAG_W-1:0]  w_fill_tag;
    logic [VW-1:0]     w_fill_way;
    logic              w_fill_inv;
    logic [ADDR_W-1:0] w_start_addr;

    assign w_idx        = pc_i[IDX_W+1:2];
    assign w_tag        = pc_i[ADDR_W-1:IDX_W+2];
    assign w_fill       = r_mem_req && mem_done_i;
    assign w_fill_idx   = r_mem_addr[IDX_W+1:2];
    assign w_fill_tag   = r_mem_addr[ADDR_W-1:IDX_W+2];
    assign w_fwd        = w_fill && (r_mem_addr == pc_i);
    assign w_miss       = !rst && !w_hit && !w_fwd;
    assign w_start_addr = {pc_i[ADDR_W-1:2], 2'b00};

    assign mem_req_o  = r_mem_req && !mem_done_i;
    assign mem_addr_o = r_mem_addr;

    always_comb begin
        w_hit      = 1'b0;
        w_hit_data = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
                w_hit      = 1'b1;
                w_hit_data = r_data[w_idx][w];
            end
        end
    end

    // Lowest-numbered invalid way beats the round-robin pointer.
    always_comb begin
        w_fill_way = r_victim[w_fill_idx];
        w_fill_inv = 1'b0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!w_fill_inv && !r_valid[w_fill_idx][w]) begin
                w_fill_inv = 1'b1;
                w_fill_way = VW'(w);
            end
        end
    end

`ifdef IF_PREFETCH_EN
    logic [ADDR_W-1:0] w_pf_addr;
    logic              w_pf_hit;

    assign w_pf_addr = r_mem_addr + ADDR_W'(4);

    always_comb begin
        w_pf_hit = 1'b0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (r_valid[w_pf_addr[IDX_W+1:2]][w] &&
                (r_tag[w_pf_addr[IDX_W+1:2]][w] == w_pf_addr[ADDR_W-1:IDX_W+2]))
                w_pf_hit = 1'b1;
        end
    end
`endif

    always_comb begin
        inst_o   = '0;
        pc_o     = '0;
        if_stall = 1'b0;
        if (!rst) begin
            if (w_fwd) begin
                inst_o = mem_data_i;
                pc_o   = pc_i;
            end else if (w_hit) begin
                inst_o = w_hit_data;
                pc_o   = pc_i;
            end else begin
                if_stall = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                r_victim[s] <= '0;
                for (int unsigned w = 0; w < WAYS; w++)
                    r_valid[s][w] <= 1'b0;
            end
        end else begin
            if (w_fill) begin
                if (!w_fill_inv)
                    r_victim[w_fill_idx] <= (r_victim[w_fill_idx] == VW'(WAYS - 1)) ?
                                            '0 : r_victim[w_fill_idx] + VW'(1);
                if (!r_drop)
                    r_valid[w_fill_idx][w_fill_way] <= 1'b1;
            end
            // Flush is last so it overrides a same-cycle fill.
            if (flush_i) begin
                for (int unsigned s = 0; s < SETS; s++)
                    for (int unsigned w = 0; w < WAYS; w++)
                        r_valid[s][w] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_tag[w_fill_idx][w_fill_way]  <= w_fill_tag;
            r_data[w_fill_idx][w_fill_way] <= mem_data_i;
        end
    end

    // A done cycle may chain straight into the next request, so a redirect
    // seen during the refill is issued the cycle after the old line lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
            r_drop     <= 1'b0;
        end else begin
            if (flush_i)
                r_drop <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_miss) begin
                        r_state    <= S_REQ;
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= w_start_addr;
                        r_drop     <= 1'b0;
                    end
                end
                S_REQ: begin
                    if (mem_done_i) begin
`ifdef IF_PREFETCH_EN
                        if (!w_pf_hit) begin
                            r_state    <= S_PF;
                            r_mem_req  <= 1'b1;
                            r_mem_addr <= w_pf_addr;
                            r_drop     <= 1'b0;
                        end else
`endif
                        if (w_miss) begin
                            r_state    <= S_REQ;
                            r_mem_req  <= 1'b1;
                            r_mem_addr <= w_start_addr;
                            r_drop     <= 1'b0;
                        end else begin
                            r_state   <= S_IDLE;
                            r_mem_req <= 1'b0;
                        end
                    end
                end
`ifdef IF_PREFETCH_EN
                S_PF: begin
                    if (mem_done_i) begin
                        if (w_miss) begin
                            r_state    <= S_REQ;
                            r_mem_req  <= 1'b1;
                            r_mem_addr <= w_start_addr;
                            r_drop     <= 1'b0;
                        end else begin
                            r_state   <= S_IDLE;
                            r_mem_req <= 1'b0;
                        end
                    end
                end
`endif
                default: begin
                    r_state   <= S_IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_sa_cache.sv
// Directed bench for if_sa_cache; memory answers word A with A + 0x13 after 3 request cycles.
module tb_if_sa_cache;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_i;
    logic        flush_i;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic        if_stall;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_i;
    logic        mem_done_i;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          mem_lat  = 3;
    int          done_cnt = 0;
    logic [31:0] last_done_addr = '0;

    always #5 clk = ~clk;

    if_sa_cache #(
        .ADDR_W(32),
        .IDX_W (7),
        .WAYS  (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pc_i      (pc_i),
        .flush_i   (flush_i),
        .inst_o    (inst_o),
        .pc_o      (pc_o),
        .if_stall  (if_stall),
        .mem_req_o (mem_req_o),
        .mem_addr_o(mem_addr_o),
        .mem_data_i(mem_data_i),
        .mem_done_i(mem_done_i)
    );

    // Memory responder: counts cycles with the request seen high.
    initial begin
        int          cnt;
        logic        req;
        logic        rs;
        logic [31:0] addr;
        cnt        = 0;
        mem_done_i = 1'b0;
        mem_data_i = '0;
        forever begin
            @(negedge clk);
            req  = mem_req_o;
            rs   = rst;
            addr = mem_addr_o;
            @(posedge clk);
            #1;
            mem_done_i = 1'b0;
            if (rs || !req) begin
                cnt = 0;
            end else begin
                cnt++;
                if (cnt >= mem_lat) begin
                    mem_done_i     = 1'b1;
                    mem_data_i     = addr + 32'h13;
                    last_done_addr = addr;
                    done_cnt++;
                    cnt = 0;
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic fetch(input logic [31:0] pc, output int stalls,
                         output logic [31:0] inst, output logic [31:0] pco);
        bit got;
        got    = 1'b0;
        stalls = 0;
        inst   = 'x;
        pco    = 'x;
        pc_i   = pc;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (!if_stall) begin
                inst = inst_o;
                pco  = pc_o;
                got  = 1'b1;
            end else begin
                stalls++;
            end
            @(posedge clk);
            #1;
        end
        if (!got) stalls = -1;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (mem_done_i) ok = 1'b1;
        end
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        flush_i = 1'b0;
        pc_i    = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        flush_i = 1'b0;
        pc_i    = 32'h40;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++; if (inst_o !== 32'h0) $display("FAIL rst_inst: got %h want %h", inst_o, 32'h0); else n_pass++;
        n_checks++; if (pc_o !== 32'h0) $display("FAIL rst_pc: got %h want %h", pc_o, 32'h0); else n_pass++;
        n_checks++; if (if_stall !== 1'b0) $display("FAIL rst_stall: got %b want 0", if_stall); else n_pass++;
        n_checks++; if (mem_req_o !== 1'b0) $display("FAIL rst_req: got %b want 0", mem_req_o); else n_pass++;
        n_checks++; if (mem_addr_o !== 32'h0) $display("FAIL rst_addr: got %h want %h", mem_addr_o, 32'h0); else n_pass++;
        @(posedge clk);
        #1;
        pc_i = '0;
        rst  = 1'b0;
    endtask

    task automatic test_basic();
        int s;
        logic [31:0] i, p;
        fetch(32'h0, s, i, p);
        n_checks++; if (s !== 4) $display("FAIL basic_miss_stall: got %0d want 4", s); else n_pass++;
        n_checks++; if (i !== 32'h13) $display("FAIL basic_fwd_inst: got %h want %h", i, 32'h13); else n_pass++;
        n_checks++; if (p !== 32'h0) $display("FAIL basic_fwd_pc: got %h want %h", p, 32'h0); else n_pass++;
        n_checks++; if (last_done_addr !== 32'h0) $display("FAIL basic_req_addr: got %h want %h", last_done_addr, 32'h0); else n_pass++;
        fetch(32'h0, s, i, p);
        n_checks++; if (s !== 0) $display("FAIL basic_hit_stall: got %0d want 0", s); else n_pass++;
        n_checks++; if (i !== 32'h13) $display("FAIL basic_hit_inst: got %h want %h", i, 32'h13); else n_pass++;
    endtask

    task automatic test_conflict();
        int s;
        logic [31:0] i, p;
        do_reset();
        fetch(32'h000, s, i, p);
        n_checks++; if (s !== 4) $display("FAIL conf_0_stall: got %0d want 4", s); else n_pass++;
        fetch(32'h200, s, i, p);
        n_checks++; if (s !== 4) $display("FAIL conf_200_stall: got %0d want 4", s); else n_pass++;
        n_checks++; if (i !== 32'h213) $display("FAIL conf_200_inst: got %h want %h", i, 32'h213); else n_pass++;
        fetch(32'h400, s, i, p);
        n_checks++; if (s !== 4) $display("FAIL conf_400_stall: got %0d want 4", s); else n_pass++;
        n_checks++; if (i !== 32'h413) $display("FAIL conf_400_inst: got %h want %h", i, 32'h413); else n_pass++;
        fetch(32'h200, s, i, p);
        n_checks++; if (s !== 0) $display("FAIL conf_200_hit_stall: got %0d want 0", s); else n_pass++;
        n_checks++; if (i !== 32'h213) $display("FAIL conf_200_hit_inst: got %h want %h", i, 32'h213); else n_pass++;
        fetch(32'h000, s, i, p);
        n_checks++; if (s !== 4) $display("FAIL conf_0_evicted_stall: got %0d want 4", s); else n_pass++;
        n_checks++; if (i !== 32'h13) $display("FAIL conf_0_refill_inst: got %h want %h", i, 32'h13); else n_pass++;
        fetch(32'h400, s, i, p);
        n_checks++; if (s !== 0) $display("FAIL conf_400_hit_stall: got %0d want 0", s); else n_pass++;
        fetch(32'h200, s, i, p);
        n_checks++; if (s !== 4) $display("FAIL conf_200_evicted_stall: got %0d want 4", s); else n_pass++;
    endtask

    task automatic test_redirect();
        int s;
        logic [31:0] i, p;
        bit ok;
        do_reset();
        pc_i = 32'h100;
        repeat (2) begin @(posedge clk); #1; end
        pc_i = 32'h180;
        wait_done(ok);
        n_checks++; if (!ok) $display("FAIL redir_done_timeout: got no done want done"); else n_pass++;
        n_checks++; if (last_done_addr !== 32'h100) $display("FAIL redir_done_addr: got %h want %h", last_done_addr, 32'h100); else n_pass++;
        n_checks++; if (if_stall !== 1'b1) $display("FAIL redir_no_fwd: got %b want 1", if_stall); else n_pass++;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++; if (mem_req_o !== 1'b1) $display("FAIL redir_new_req: got %b want 1", mem_req_o); else n_pass++;
        n_checks++; if (mem_addr_o !== 32'h180) $display("FAIL redir_new_addr: got %h want %h", mem_addr_o, 32'h180); else n_pass++;
        @(posedge clk); #1;
        pc_i = 32'h100;
        @(negedge clk);
        n_checks++; if (if_stall !== 1'b0) $display("FAIL redir_hit_during_req: got %b want 0", if_stall); else n_pass++;
        n_checks++; if (inst_o !== 32'h113) $display("FAIL redir_hit_inst: got %h want %h", inst_o, 32'h113); else n_pass++;
        @(posedge clk); #1;
        fetch(32'h180, s, i, p);
        n_checks++; if (i !== 32'h193) $display("FAIL redir_180_inst: got %h want %h", i, 32'h193); else n_pass++;
        fetch(32'h100, s, i, p);
        n_checks++; if (s !== 0) $display("FAIL redir_100_hit_stall: got %0d want 0", s); else n_pass++;
    endtask

    task automatic test_flush();
        int s;
        logic [31:0] i, p;
        bit ok;
        do_reset();
        fetch(32'h000, s, i, p);
        fetch(32'h200, s, i, p);
        pc_i = 32'h40;
        wait_done(ok);
        n_checks++; if (!ok) $display("FAIL flush_done_timeout: got no done want done"); else n_pass++;
        n_checks++; if (if_stall !== 1'b0) $display("FAIL flush_fwd_stall: got %b want 0", if_stall); else n_pass++;
        n_checks++; if (inst_o !== 32'h53) $display("FAIL flush_fwd_inst: got %h want %h", inst_o, 32'h53); else n_pass++;
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        fetch(32'h40, s, i, p);
        n_checks++; if (s !== 4) $display("FAIL flush_40_stall: got %0d want 4", s); else n_pass++;
        fetch(32'h000, s, i, p);
        n_checks++; if (s !== 4) $display("FAIL flush_0_stall: got %0d want 4", s); else n_pass++;
        fetch(32'h200, s, i, p);
        n_checks++; if (s !== 4) $display("FAIL flush_200_stall: got %0d want 4", s); else n_pass++;
        pc_i = 32'h80;
        repeat (2) begin @(posedge clk); #1; end
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        wait_done(ok);
        n_checks++; if (!ok) $display("FAIL flush_req_done_timeout: got no done want done"); else n_pass++;
        n_checks++; if (inst_o !== 32'h93) $display("FAIL flush_req_fwd_inst: got %h want %h", inst_o, 32'h93); else n_pass++;
        @(posedge clk); #1;
        fetch(32'h80, s, i, p);
        n_checks++; if (s !== 4) $display("FAIL flush_req_not_cached: got %0d want 4", s); else n_pass++;
    endtask

    task automatic test_reset_mid_req();
        int s;
        logic [31:0] i, p;
        do_reset();
        fetch(32'h000, s, i, p);
        pc_i = 32'h300;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst  = 1'b0;
        pc_i = 32'h0;
        @(negedge clk);
        n_checks++; if (mem_req_o !== 1'b0) $display("FAIL rstmid_req: got %b want 0", mem_req_o); else n_pass++;
        n_checks++; if (if_stall !== 1'b1) $display("FAIL rstmid_line_gone: got %b want 1", if_stall); else n_pass++;
        @(posedge clk); #1;
        fetch(32'h0, s, i, p);
        n_checks++; if (s !== 3) $display("FAIL rstmid_refill_stall: got %0d want 3", s); else n_pass++;
        n_checks++; if (i !== 32'h13) $display("FAIL rstmid_refill_inst: got %h want %h", i, 32'h13); else n_pass++;
        n_checks++; if (last_done_addr !== 32'h0) $display("FAIL rstmid_done_addr: got %h want %h", last_done_addr, 32'h0); else n_pass++;
    endtask

`ifdef IF_PREFETCH_EN
    task automatic test_prefetch();
        int s;
        logic [31:0] i, p;
        bit ok;
        do_reset();
        fetch(32'h10, s, i, p);
        n_checks++; if (s !== 4) $display("FAIL pf_demand_stall: got %0d want 4", s); else n_pass++;
        n_checks++; if (i !== 32'h23) $display("FAIL pf_demand_inst: got %h want %h", i, 32'h23); else n_pass++;
        @(negedge clk);
        n_checks++; if (mem_req_o !== 1'b1) $display("FAIL pf_req: got %b want 1", mem_req_o); else n_pass++;
        n_checks++; if (mem_addr_o !== 32'h14) $display("FAIL pf_addr: got %h want %h", mem_addr_o, 32'h14); else n_pass++;
        wait_done(ok);
        n_checks++; if (!ok) $display("FAIL pf_done_timeout: got no done want done"); else n_pass++;
        @(posedge clk); #1;
        fetch(32'h14, s, i, p);
        n_checks++; if (s !== 0) $display("FAIL pf_hit_stall: got %0d want 0", s); else n_pass++;
        n_checks++; if (i !== 32'h27) $display("FAIL pf_hit_inst: got %h want %h", i, 32'h27); else n_pass++;
        fetch(32'hFFFF_FFFC, s, i, p);
        n_checks++; if (i !== 32'h0000_000F) $display("FAIL pf_top_inst: got %h want %h", i, 32'h0000_000F); else n_pass++;
        @(negedge clk);
        n_checks++; if (mem_addr_o !== 32'h0) $display("FAIL pf_wrap_addr: got %h want %h", mem_addr_o, 32'h0); else n_pass++;
        wait_done(ok);
        @(posedge clk); #1;
        fetch(32'h0, s, i, p);
        n_checks++; if (s !== 0) $display("FAIL pf_wrap_hit_stall: got %0d want 0", s); else n_pass++;
        n_checks++; if (i !== 32'h13) $display("FAIL pf_wrap_hit_inst: got %h want %h", i, 32'h13); else n_pass++;
    endtask
`endif

    initial begin
        rst     = 1'b1;
        flush_i = 1'b0;
        pc_i    = '0;
        test_reset();
`ifdef IF_PREFETCH_EN
        test_prefetch();
`else
        test_basic();
        test_conflict();
        test_redirect();
        test_flush();
        test_reset_mid_req();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/if_sa_cache.md
Name: if_sa_cache

Overview:
- Instruction-fetch stage with a parametrised N-way set-associative instruction cache, one 32-bit word per line.
- Sits between pc_reg and if_id and issues single-word refills to mem_ctrl over a req/done handshake.
- Adds over the direct-mapped fetch stage: configurable sets and ways, round-robin replacement, cache flush (fence.i), a registered miss FSM that tolerates PC redirects mid-refill, and optional next-line prefetch.

Parameters:
- ADDR_W, 32, PC/address width in bits.
- IDX_W, 7, set index bits; SETS = 2**IDX_W.
- WAYS, 2, associativity; legal values 1, 2, 4.
- TAG_W, ADDR_W-IDX_W-2, derived; do not override.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- pc_i  in  ADDR_W  fetch PC from pc_reg
- flush_i  in  1  invalidate the whole cache (fence.i)
- inst_o  out  32  instruction to if_id
- pc_o  out  ADDR_W  PC of inst_o
- if_stall  out  1  fetch not ready this cycle
- mem_req_o  out  1  refill request to mem_ctrl
- mem_addr_o  out  ADDR_W  refill word address, bits [1:0] = 0
- mem_data_i  in  32  refill data
- mem_done_i  in  1  one-cycle pulse; mem_data_i is valid in that cycle

Behaviour:
- Storage per set and way: valid, tag, data. Per set: a round-robin victim pointer of log2(WAYS) bits.
- Address split: idx = pc_i[IDX_W+1:2], tag = pc_i[ADDR_W-1:IDX_W+2].
- Lookup is combinational. Hit = any way with valid && tag match. On hit, in the same cycle: inst_o = data, pc_o = pc_i, if_stall = 0.
- Forwarding: mem_done_i with refill address == pc_i counts as a hit. inst_o = mem_data_i in that cycle, if_stall = 0.
- Otherwise: inst_o = 0, pc_o = 0, if_stall = 1.
- Reset: all valid bits = 0, victim pointers = 0, FSM = IDLE, mem_req_o = 0, mem_addr_o = 0. Outputs read inst_o = 0, pc_o = 0, if_stall = 0 while rst is high.
- FSM states: IDLE, REQ, PF (PF exists only with the optional feature).
  - IDLE -> REQ when lookup misses. Next cycle: mem_addr_o <= {pc_i[ADDR_W-1:2], 2'b00}, mem_req_o <= 1.
  - REQ: hold mem_req_o and mem_addr_o stable until mem_done_i. Deassert mem_req_o in the same cycle as mem_done_i, via the combinational term mem_req_o_reg && !mem_done_i.
  - REQ on mem_done_i: write the line into the victim way of the refill set, set valid, advance that set's victim pointer by 1 mod WAYS, return to IDLE.
  - Invalid ways take priority over the victim pointer; the lowest-numbered invalid way is chosen. The pointer does not advance when an invalid way is filled.
- PC redirect during REQ: the outstanding refill always completes and is written; it is never cancelled. The new pc_i misses in the following cycle and starts a new refill. There is never more than one outstanding request.
- Flush: flush_i clears every valid bit in one cycle.
  - flush_i in the same cycle as a refill write: flush wins and the line is not marked valid.
  - flush_i during REQ: the request is not aborted. Its returning data is forwarded if its address == pc_i, but it is not cached.
  - Victim pointers are unaffected by flush.
- Hits never modify state. A hit on line X while the FSM is in REQ for line Y is served with if_stall = 0.
- Wrap-around: the PC is compared on all ADDR_W bits. Aliasing sets use tag compare only, so no false hits.

Optional Feature:
- Macro: IF_PREFETCH_EN.
- With the macro: after a demand refill of address A completes, if A+4 misses in its set, the FSM enters PF and issues A+4 on the same handshake.
  - PF fills exactly like REQ.
  - A demand miss during PF waits for PF to finish; if_stall = 1 until then, except when the PF data forwards to a matching pc_i.
  - A+4 overflow wraps modulo 2**ADDR_W.
  - No prefetch is issued after a prefetch.
- Without the macro: the PF state and its logic are absent, and refills are demand-only.

Test Plan:
- Reset, then pc_i = 0x0000_0000 with mem returning 0x0000_0013 after 3 cycles -> if_stall high for 4 cycles, mem_addr_o = 0x0; forward cycle inst_o = 0x13; re-fetch of 0x0 hits with 0 stall.
- Conflict with WAYS = 2, IDX_W = 7: fetch 0x000, 0x200, 0x400 -> 3 misses; then 0x200 hits and 0x000 misses (round-robin evicted way 0).
- Redirect: miss on 0x100, pc_i changes to 0x180 two cycles later -> 0x100 is still written when mem_done_i arrives; next cycle mem_addr_o = 0x180; a later fetch of 0x100 hits.
- flush_i asserted in the same cycle as mem_done_i for 0x40 -> forward to pc_i = 0x40 happens; the next fetch of 0x40 misses; earlier lines 0x0 and 0x200 also miss.
- rst asserted mid-REQ -> mem_req_o = 0 the next cycle, all prior lines miss, FSM = IDLE.
- With IF_PREFETCH_EN: miss on 0x10 -> after its done, mem_addr_o = 0x14 with no demand; pc_i = 0x14 then hits with 0 stall; pc_i = 0xFFFF_FFFC refill prefetches 0x0000_0000.
